// File: rtl/psmac_pkg.sv
// Shared types and lane-geometry helpers for the precision-scalable MAC.
package psmac_pkg;

   typedef enum logic [1:0] {
      MODE_FULL  = 2'b00,
      MODE_HALF  = 2'b01,
      MODE_SLICE = 2'b10,
      MODE_RSVD  = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ACC   = 2'd0,
      FLUSH = 2'd1,
      OUT   = 2'd2
   } state_e;

   function automatic int lane_width(mode_e m, int nslice, int lane_w);
      case (m)
         MODE_FULL: return nslice * lane_w;
         MODE_HALF: return (nslice * lane_w) / 2;
         default:   return lane_w;
      endcase
   endfunction

   // Segment k starts a lane: no carry may enter it from segment k-1.
   function automatic logic seg_lsb(mode_e m, int k, int nslice);
      return (m == MODE_SLICE) || (k == 0) || ((m == MODE_HALF) && (k == nslice / 2));
   endfunction

   // Segment k holds the sign of its lane (also: top weight slice of its group).
   function automatic logic seg_msb(mode_e m, int k, int nslice);
      return (m == MODE_SLICE) || (k == nslice - 1) || ((m == MODE_HALF) && (k == nslice / 2 - 1));
   endfunction

endpackage

// File: rtl/psmac_slice_mult.sv
// Signed activation times one weight slice; slice is signed or unsigned per is_signed.
module psmac_slice_mult #(
   parameter  int ACT_W   = 8,
   parameter  int SLICE_W = 2,
   localparam int PW      = ACT_W + SLICE_W
) (
   input  logic [ACT_W-1:0]   act,
   input  logic [SLICE_W-1:0] slice,
   input  logic               is_signed,
   output logic [PW-1:0]      prod
);

   logic signed [PW-1:0] a_ext, w_ext;

   // PW bits hold the exact product for both signed and unsigned slices.
   assign a_ext = {{SLICE_W{act[ACT_W-1]}}, act};
   assign w_ext = {{ACT_W{is_signed & slice[SLICE_W-1]}}, slice};
   assign prod  = a_ext * w_ext;

endmodule

// File: rtl/prec_scalable_mac.sv
// Precision-scalable MAC: full/half/slice products accumulated per lane, valid/ready out.
// Define PSMAC_SAT_EN for per-lane saturation instead of modular wrap.
module prec_scalable_mac
   import psmac_pkg::*;
#(
   parameter  int ACT_W   = 8,
   parameter  int SLICE_W = 2,
   parameter  int NSLICE  = 4,
   parameter  int LANE_W  = 14,
   localparam int WGT_W   = SLICE_W * NSLICE,
   localparam int ACC_W   = NSLICE * LANE_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [ACT_W-1:0] in_act,
   input  logic [WGT_W-1:0]        in_wgt,
   input  logic                    in_last,
   input  logic [1:0]              prec_mode,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ACC_W-1:0]        acc_o,
   output logic [1:0]              mode_o,
   output logic                    mode_err
);

   localparam int PW     = ACT_W + SLICE_W;
   localparam int HALF_W = lane_width(MODE_HALF, NSLICE, LANE_W);
   localparam int GRP    = NSLICE / 2;
   localparam int STAGES = 1;

   typedef struct packed {
      mode_e                         mode;
      logic [NSLICE-1:0][LANE_W-1:0] prod;
   } s1_t;

   state_e                        state;
   mode_e                         mode_q, eff_mode;
   logic                          first_q, accept;
   logic [STAGES:0]               vld_pipe;
   s1_t                           s1_q;
   logic [NSLICE-1:0]             sgn;
   logic [NSLICE-1:0][PW-1:0]     sp;
   logic [ACC_W-1:0]              p_full, prod_d;
   logic [1:0][HALF_W-1:0]        p_half;
   logic [NSLICE-1:0][LANE_W-1:0] p_slice, acc_q, acc_n, sum_seg;

   assign accept   = in_valid && in_ready;
   assign eff_mode = first_q ? mode_e'(prec_mode) : mode_q;
   assign acc_o    = acc_q;
   assign mode_o   = mode_q;

   generate
      for (genvar k = 0; k < NSLICE; k++) begin : g_lane
         assign sgn[k] = seg_msb(eff_mode, k, NSLICE);
         psmac_slice_mult #(.ACT_W(ACT_W), .SLICE_W(SLICE_W)) u_mult (
            .act       (in_act),
            .slice     (in_wgt[k*SLICE_W +: SLICE_W]),
            .is_signed (sgn[k]),
            .prod      (sp[k])
         );
      end
   endgenerate

   // Recombine shifted slice partials into the lane layout of the active mode.
   always_comb begin
      p_full  = '0;
      p_half  = '0;
      p_slice = '0;
      for (int k = 0; k < NSLICE; k++) begin
         p_full = p_full + ({{(ACC_W-PW){sp[k][PW-1]}}, sp[k]} << (k * SLICE_W));
         p_half[k/GRP] = p_half[k/GRP] + ({{(HALF_W-PW){sp[k][PW-1]}}, sp[k]} << ((k % GRP) * SLICE_W));
         p_slice[k] = {{(LANE_W-PW){sp[k][PW-1]}}, sp[k]};
      end
      case (eff_mode)
         MODE_FULL:  prod_d = p_full;
         MODE_HALF:  prod_d = p_half;
         MODE_SLICE: prod_d = p_slice;
         default:    prod_d = '0;
      endcase
   end

`ifdef PSMAC_SAT_EN
   logic [NSLICE-1:0] ovf_seg;
`endif

   // Segmented adder: carries ripple between segments only inside a lane.
   always_comb begin : add_chain
      logic            c;
      logic [LANE_W:0] s;
      c       = 1'b0;
      s       = '0;
      sum_seg = '0;
`ifdef PSMAC_SAT_EN
      ovf_seg = '0;
`endif
      for (int k = 0; k < NSLICE; k++) begin
         s = {1'b0, acc_q[k]} + {1'b0, s1_q.prod[k]}
             + {{LANE_W{1'b0}}, (c & ~seg_lsb(s1_q.mode, k, NSLICE))};
         c          = s[LANE_W];
         sum_seg[k] = s[LANE_W-1:0];
`ifdef PSMAC_SAT_EN
         ovf_seg[k] = (acc_q[k][LANE_W-1] == s1_q.prod[k][LANE_W-1]) &&
                      (s[LANE_W-1] != acc_q[k][LANE_W-1]);
`endif
      end
   end

`ifdef PSMAC_SAT_EN
   // Walk top-down so each lane's overflow verdict covers all its segments.
   always_comb begin : sat
      logic ovf, neg;
      ovf   = 1'b0;
      neg   = 1'b0;
      acc_n = sum_seg;
      for (int k = NSLICE - 1; k >= 0; k--) begin
         if (seg_msb(s1_q.mode, k, NSLICE)) begin
            ovf = ovf_seg[k];
            neg = acc_q[k][LANE_W-1];
         end
         if (ovf)
            acc_n[k] = seg_msb(s1_q.mode, k, NSLICE) ? {neg, {(LANE_W-1){~neg}}}
                                                     : {LANE_W{~neg}};
      end
   end
`else
   assign acc_n = sum_seg;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe    <= '0;
         s1_q.mode   <= MODE_FULL;
         s1_q.prod   <= '0;
         acc_q       <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:0], accept};
         if (accept) begin
            s1_q.mode <= eff_mode;
            s1_q.prod <= prod_d;
         end
         if (vld_pipe[0])
            acc_q <= acc_n;
         else if (out_valid && out_ready)
            acc_q <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACC;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         mode_q    <= MODE_FULL;
         first_q   <= 1'b1;
         mode_err  <= 1'b0;
      end else begin
         case (state)
            ACC: begin
               in_ready <= 1'b1;
               if (accept) begin
                  first_q <= 1'b0;
                  if (first_q) mode_q <= eff_mode;
                  if (eff_mode == MODE_RSVD) mode_err <= 1'b1;
                  if (in_last) begin
                     state    <= FLUSH;
                     in_ready <= 1'b0;
                  end
               end
            end
            // Last beat has reached the accumulator once it leaves stage 1 alone.
            FLUSH: if (vld_pipe[1] && !vld_pipe[0]) begin
               state     <= OUT;
               out_valid <= 1'b1;
            end
            OUT: if (out_ready) begin
               state     <= ACC;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               mode_q    <= MODE_FULL;
               first_q   <= 1'b1;
            end
            default: state <= ACC;
         endcase
      end
   end

endmodule

// File: doc/prec_scalable_mac.md
Name: prec_scalable_mac

Overview:
- Parametrised precision-scalable multiply-accumulate engine for the 2020 accelerator datapath.
- Splits a WGT_W-bit weight into NSLICE slices of SLICE_W bits and runs three modes: one full-precision product, two half-precision products, or NSLICE slice-precision products per beat.
- Accumulates a vector of beats into independent lanes, then presents the result through a valid/ready handshake.
- Successor to the fixed 8-bit, 4-slice MAC: adds parametrised widths, pipelining, vector framing and backpressure.

Parameters:
- ACT_W, 8, activation width; signed two's complement.
- SLICE_W, 2, weight slice width.
- NSLICE, 4, slices per weight; WGT_W = SLICE_W*NSLICE. Must be a power of 2, at least 2.
- LANE_W, 14, accumulator bits per slice lane; ACC_W = NSLICE*LANE_W.

Ports:
- clk, in, 1: clock; all logic on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: input beat valid.
- in_ready, out, 1: block can accept a beat.
- in_act, in, ACT_W: signed activation.
- in_wgt, in, WGT_W: weight; slice k = bits [k*SLICE_W +: SLICE_W].
- in_last, in, 1: last beat of the vector.
- prec_mode, in, 2: 00 full, 01 half, 10 slice, 11 reserved.
- out_valid, out, 1: result valid.
- out_ready, in, 1: consumer accepts the result.
- acc_o, out, ACC_W: accumulated lanes.
- mode_o, out, 2: mode of the presented vector.
- mode_err, out, 1: sticky flag, reserved mode seen.

Behaviour:
- Reset: the synchronous, active-high rst takes effect at the next clk edge.
  - All outputs go to 0, the state goes to ACC, the pipeline is emptied and the accumulator is zeroed.
  - Reset mid-vector or mid-hold discards everything.
- Handshakes: an input beat is accepted when in_valid && in_ready. The output is consumed when out_valid && out_ready.
- State machine:
  - ACC: in_ready=1.
    - On the first accepted beat of a vector, prec_mode is latched.
    - prec_mode is ignored on later beats of the same vector.
    - An accepted beat with in_last=1 moves the state to FLUSH.
  - FLUSH: in_ready=0. Wait 2 cycles for the pipeline to drain, then go to OUT.
  - OUT: out_valid=1 and in_ready=0. acc_o and mode_o stay stable until out_ready.
    - On the handshake: the accumulator and latched mode are cleared, out_valid drops next cycle, and the state returns to ACC.
- Latency: a beat accepted at cycle t has its product registered at t+1 and accumulated at t+2. For a last beat at t, out_valid=1 from t+3.
- Products:
  - A signed ACT_W × SLICE_W slice product is computed per slice. The top slice of each group is signed; lower slices are unsigned.
  - Full mode: one ACT_W×WGT_W product with full carry across all lanes. ACC_W is a single signed lane.
  - Half mode: two (WGT_W/2)-bit signed weights; lane h spans bits [h*ACC_W/2 +: ACC_W/2].
  - Slice mode: each slice is a signed weight; lane k spans bits [k*LANE_W +: LANE_W].
  - Each product is sign-extended to its lane width.
  - Carries are broken at lane boundaries of the active mode; each lane wraps modulo 2^lane width.
- Reserved mode 11: beats are accepted, products are forced to 0, and mode_err is set. mode_err clears only on rst.
- Simultaneous events: in OUT, in_valid is ignored (in_ready=0). A beat with in_last=1 arriving as the first beat is a 1-beat vector.

Optional Feature:
- PSMAC_SAT_EN defined: each lane saturates at its signed min/max instead of wrapping. Once saturated, a lane holds that value until the next beat moves it back in range.
- PSMAC_SAT_EN undefined: modular wrap per lane, with no saturation logic.

Decomposition:
- psmac_pkg holds:
  - the mode enum (MODE_FULL, MODE_HALF, MODE_SLICE, MODE_RSVD);
  - the state enum (ACC, FLUSH, OUT);
  - lane-width helper functions.
- Sub-module psmac_slice_mult: signed ACT_W × SLICE_W multiplier with a signed/unsigned weight control, instantiated NSLICE times.

Test Plan:
- Full mode, beats (2,3),(4,5),(-1,7) with last on the third → out_valid 3 cycles after the last beat, acc_o=19, mode_o=00.
- Slice mode, in_act=10, in_wgt=8'b11_10_01_00, last → lanes 3..0 = -10, -20, 10, 0.
- Half mode, in_act=100, in_wgt=8'h7F, last → lane1=700, lane0=-100 (28-bit lanes).
- Slice mode, 32 beats of act=-128, wgt=8'hAA (all slices -2), i.e. 256 per beat:
  - without PSMAC_SAT_EN → each lane=-8192 (wrap);
  - with PSMAC_SAT_EN → each lane=8191.
- out_ready held 0 for 5 cycles in OUT → acc_o stable and in_ready=0. After the handshake, in_ready=1 next cycle and the accumulator is 0.
- rst asserted mid-vector, then prec_mode=11 beat with last → first acc_o=0; reserved vector acc_o=0 with mode_err=1 sticky until rst.
